aes_dpc_multi: RTL and testbench

Iterative AES round datapath supporting AES-128/192/256 in both directions, one round per clock. It is the next generation of the AES-128 encrypt/decrypt core. It takes a pre-expanded round-key bus from the key-expansion block and keeps the S-box external, so several cores can share S-box instances. Compared with the previous core it adds:
- a per-block key-size mode;
- valid/ready handshakes on input and output, with output back-pressure;
- a rejection path for unsupported modes.

---
 rtl/aes_dpc_multi_pkg.sv | 61 ++++++
 rtl/aes_mixcol_w.sv | 38 +++
 rtl/aes_dpc_multi.sv | 155 +++++++++++++++
 tb/tb_aes_dpc_multi.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dpc_multi_pkg.sv
// aes_dpc_multi_pkg
//   Shared definitions for the iterative AES round datapath: key-size mode
//   codes, round count per mode, FSM states, GF(2^8) doubling and the
//   ShiftRows / InvShiftRows byte mapping (kept here for reuse by multi-lane
//   cores). Replaces the former aes_dpc_defs.vh include.
package aes_dpc_multi_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'b00,
    MODE_192  = 2'b01,
    MODE_256  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } state_e;

  localparam logic [3:0] NR_128  = 4'd10;
  localparam logic [3:0] NR_192  = 4'd12;
  localparam logic [3:0] NR_256  = 4'd14;
  // Reserved mode maps above any buildable round count so a single
  // "Nr <= NR_MAX" test rejects it.
  localparam logic [3:0] NR_RSVD = 4'd15;

  function automatic logic [3:0] nr_of_mode(input mode_e mode);
    case (mode)
      MODE_128: return NR_128;
      MODE_192: return NR_192;
      MODE_256: return NR_256;
      default:  return NR_RSVD;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Source byte index feeding output byte idx (byte 0 = bits [127:120],
  // column-major: idx = row + 4*col).
  function automatic int unsigned sr_src(input int unsigned idx, input logic inv);
    int unsigned row;
    int unsigned col;
    row = idx % 4;
    col = idx / 4;
    if (inv) return row + 4 * ((col + 4 - row) % 4);
    return row + 4 * ((col + row) % 4);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = s[127 - 8 * sr_src(i, inv) -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcol_w.sv
// aes_mixcol_w
//   One 32-bit AES column: forward and inverse MixColumns in parallel.
//   din : input column, AES row 0 in [31:24]
//   x   : MixColumns(din)
//   y   : InvMixColumns(din)
module aes_mixcol_w
  import aes_dpc_multi_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] x,
  output logic [31:0] y
);

  function automatic logic [31:0] mix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [7:0] u;
  logic [7:0] v;

  // InvMixColumns = MixColumns after adding 4*(a0^a2) / 4*(a1^a3) to
  // alternate rows, which reuses the forward network.
  always_comb begin
    u = xtime(xtime(din[31:24] ^ din[15:8]));
    v = xtime(xtime(din[23:16] ^ din[7:0]));
    x = mix(din);
    y = mix(din ^ {u, v, u, v});
  end

endmodule

// File: rtl/aes_dpc_multi.sv
// aes_dpc_multi
//   Iterative AES-128/192/256 encrypt/decrypt round datapath, one round per
//   clock, with external S-box and pre-expanded round keys.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_flag, i_mode     : direction (1 = encrypt) and key size, sampled at accept
//   i_keyex            : round keys, key k at [128*(NR_MAX+1-k)-1 -: 128]
//   i_din/_vld, o_din_rdy   : input block handshake
//   o_dout/_vld, i_dout_rdy : output block handshake with back-pressure
//   o_err              : one-cycle pulse for a rejected mode
//   o_sbox_din, i_sbox_dout : (Inv)ShiftRows of state out, S-box result in
module aes_dpc_multi
  import aes_dpc_multi_pkg::*;
#(
  parameter int unsigned NR_MAX = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flag,
  input  logic [1:0]                i_mode,
  input  logic [128*(NR_MAX+1)-1:0] i_keyex,
  input  logic [127:0]              i_din,
  input  logic                      i_din_vld,
  output logic                      o_din_rdy,
  output logic [127:0]              o_dout,
  output logic                      o_dout_vld,
  input  logic                      i_dout_rdy,
  output logic                      o_err,
  output logic [127:0]              o_sbox_din,
  input  logic [127:0]              i_sbox_dout
);

  localparam int unsigned KEYEX_W  = 128 * (NR_MAX + 1);
  localparam int unsigned KB_W     = $clog2(KEYEX_W);
  localparam logic [3:0]  NR_MAX_W = 4'(NR_MAX);

  state_e        fsm_q, fsm_d;
  logic [127:0]  blk_q, blk_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    nr_q, nr_d;
  logic          dir_q, dir_d;
  logic [127:0]  dout_d;
  logic          dout_vld_d;
  logic          err_d;

  logic [3:0]    mode_nr;
  logic          mode_ok;
  logic [3:0]    key_sel;
  logic [KB_W-1:0] key_base;
  logic [127:0]  round_key;
  logic [127:0]  mc_in;
  logic [127:0]  mc_fwd;
  logic [127:0]  mc_inv;
  logic [127:0]  round_out;
  logic [127:0]  final_out;

  always_comb begin
    mode_nr   = nr_of_mode(mode_e'(i_mode));
    mode_ok   = (mode_nr <= NR_MAX_W);
    o_din_rdy = (fsm_q == ST_IDLE);
  end

  // One key port serves the accept whitening, every round and the final
  // round; clamping keeps the part-select in range for rejected modes.
  always_comb begin
    key_sel = '0;
    case (fsm_q)
      ST_IDLE:  key_sel = i_flag ? 4'd0 : mode_nr;
      ST_ROUND: key_sel = dir_q ? r_q : nr_q - r_q;
      ST_FINAL: key_sel = dir_q ? nr_q : 4'd0;
      default:  key_sel = '0;
    endcase
    if (key_sel > NR_MAX_W) key_sel = '0;
    key_base  = KB_W'(KEYEX_W - 1 - 128 * 32'(key_sel));
    round_key = i_keyex[key_base -: 128];
  end

  always_comb begin
    o_sbox_din = dir_q ? shift_rows(blk_q, 1'b0) : shift_rows(blk_q, 1'b1);
    // Decrypt adds the key before InvMixColumns, encrypt after MixColumns.
    mc_in      = dir_q ? i_sbox_dout : i_sbox_dout ^ round_key;
    round_out  = dir_q ? mc_fwd ^ round_key : mc_inv;
    final_out  = i_sbox_dout ^ round_key;
  end

  for (genvar col = 0; col < 4; col++) begin : g_col
    aes_mixcol_w u_mixcol (
      .din (mc_in [127 - 32 * col -: 32]),
      .x   (mc_fwd[127 - 32 * col -: 32]),
      .y   (mc_inv[127 - 32 * col -: 32])
    );
  end

  always_comb begin
    fsm_d      = fsm_q;
    blk_d      = blk_q;
    r_d        = r_q;
    nr_d       = nr_q;
    dir_d      = dir_q;
    dout_d     = o_dout;
    dout_vld_d = o_dout_vld & ~i_dout_rdy;
    err_d      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (i_din_vld) begin
          if (mode_ok) begin
            dir_d = i_flag;
            nr_d  = mode_nr;
            blk_d = i_din ^ round_key;
            r_d   = 4'd1;
            fsm_d = ST_ROUND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ROUND: begin
        blk_d = round_out;
        r_d   = r_q + 4'd1;
        if (r_q == nr_q - 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        // Stall with state held until the output register can take the result.
        if (!o_dout_vld || i_dout_rdy) begin
          dout_d     = final_out;
          dout_vld_d = 1'b1;
          fsm_d      = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fsm_q      <= ST_IDLE;
      blk_q      <= '0;
      r_q        <= '0;
      nr_q       <= '0;
      dir_q      <= 1'b0;
      o_dout     <= '0;
      o_dout_vld <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      blk_q      <= blk_d;
      r_q        <= r_d;
      nr_q       <= nr_d;
      dir_q      <= dir_d;
      o_dout     <= dout_d;
      o_dout_vld <= dout_vld_d;
      o_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_dpc_multi.sv
// tb_aes_dpc_multi
//   Self-checking bench for aes_dpc_multi: FIPS-197 known answers for all
//   key sizes in both directions, back-pressure, mode rejection (including a
//   NR_MAX=10 build), reset mid-block and direction/mode switching.
//   The external S-box and key expansion are modelled here.
module tb_aes_dpc_multi;

  localparam int unsigned KW  = 128 * 15;
  localparam int unsigned KWB = 128 * 11;

  localparam logic [255:0] CKEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flag;
  logic [1:0]    mode;
  logic [KW-1:0] keyex;
  logic [127:0]  din;
  logic          din_vld, din_rdy;
  logic [127:0]  dout;
  logic          dout_vld, dout_rdy;
  logic          err;
  logic [127:0]  sbox_din, sbox_dout;
  logic          use_inv;

  logic          b_din_vld, b_din_rdy;
  logic [127:0]  b_dout;
  logic          b_dout_vld, b_err;
  logic [127:0]  b_sbox_din, b_sbox_dout;

  logic [7:0]    sbox_fwd [256];
  logic [7:0]    sbox_inv [256];
  logic [KW-1:0] keys128, keys192, keys256;

  int unsigned   passed;
  int unsigned   total;

  typedef struct {
    logic         flag;
    logic [1:0]   mode;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  aes_dpc_multi #(.NR_MAX(14)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flag      (flag),
    .i_mode      (mode),
    .i_keyex     (keyex),
    .i_din       (din),
    .i_din_vld   (din_vld),
    .o_din_rdy   (din_rdy),
    .o_dout      (dout),
    .o_dout_vld  (dout_vld),
    .i_dout_rdy  (dout_rdy),
    .o_err       (err),
    .o_sbox_din  (sbox_din),
    .i_sbox_dout (sbox_dout)
  );

  aes_dpc_multi #(.NR_MAX(10)) u_dut10 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flag      (flag),
    .i_mode      (mode),
    .i_keyex     (keyex[KW-1 -: KWB]),
    .i_din       (din),
    .i_din_vld   (b_din_vld),
    .o_din_rdy   (b_din_rdy),
    .o_dout      (b_dout),
    .o_dout_vld  (b_dout_vld),
    .i_dout_rdy  (dout_rdy),
    .o_err       (b_err),
    .o_sbox_din  (b_sbox_din),
    .i_sbox_dout (b_sbox_dout)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] x, y, inv, s;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (gmul(x, y) == 8'h01) inv = y;
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_fwd[x] = s;
      sbox_inv[s] = x;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] d, input logic inv);
    logic [127:0] o;
    logic [7:0]   bt;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      bt = d[127 - 8 * i -: 8];
      o[127 - 8 * i -: 8] = inv ? sbox_inv[bt] : sbox_fwd[bt];
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_fwd[w[31:24]], sbox_fwd[w[23:16]], sbox_fwd[w[15:8]], sbox_fwd[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; key left-aligned, keys beyond Nr are zero.
  function automatic logic [KW-1:0] expand_keys(input int unsigned m, input logic [255:0] key);
    int unsigned   nk, nr;
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [127:0]  rk;
    logic [KW-1:0] bus;
    nk  = 4 + 2 * m;
    nr  = nk + 6;
    rc  = 8'h01;
    bus = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < int'(nk); i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = int'(nk); i < int'(4 * (nr + 1)); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int k = 0; k < 15; k++) begin
      rk  = (k <= int'(nr)) ? {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]} : 128'h0;
      bus = {bus[KW-129:0], rk};
    end
    return bus;
  endfunction

  always_comb sbox_dout   = sub_bytes(sbox_din, use_inv);
  always_comb b_sbox_dout = sub_bytes(b_sbox_din, 1'b0);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [KW-1:0] keys_for(input logic [1:0] m);
    return (m == 2'd0) ? keys128 : (m == 2'd1) ? keys192 : keys256;
  endfunction

  // Starts and ends #1 after a rising edge. Latency counts edges from the
  // accept edge (inclusive) to the edge that raises o_dout_vld. Inputs are
  // scrambled after accept to show they were latched.
  task automatic run_block(input logic f, input logic [1:0] m, input logic [127:0] d,
                           input logic [127:0] exp, input string name);
    int n;
    keyex   = keys_for(m);
    use_inv = ~f;
    flag    = f;
    mode    = m;
    din     = d;
    din_vld = 1'b1;
    n = 0;
    while (!din_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_rdy"}, 128'(din_rdy), 128'd1);
    @(posedge clk); #1;
    din_vld = 1'b0;
    flag    = ~f;
    mode    = 2'b11;
    din     = ~d;
    n = 1;
    while (!dout_vld && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_lat"}, 128'(n), 128'(11 + 2 * int'(m)));
    check({name, "_dout"}, dout, exp);
    check({name, "_rdy_after"}, 128'(din_rdy), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    logic hold_ok;
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    din_vld  = 1'b0;
    b_din_vld = 1'b0;
    dout_rdy = 1'b1;
    flag     = 1'b1;
    mode     = 2'b00;
    din      = '0;
    use_inv  = 1'b0;
    keyex    = '0;
    init_sbox();
    keys128 = expand_keys(0, CKEY);
    keys192 = expand_keys(1, CKEY);
    keys256 = expand_keys(2, CKEY);

    vecs[0] = '{1'b1, 2'd0, PT,   C128};
    vecs[1] = '{1'b1, 2'd1, PT,   C192};
    vecs[2] = '{1'b1, 2'd2, PT,   C256};
    vecs[3] = '{1'b0, 2'd0, C128, PT};
    vecs[4] = '{1'b0, 2'd1, C192, PT};
    vecs[5] = '{1'b0, 2'd2, C256, PT};

    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",  128'(dout_vld), 128'd0);
    check("rst_err",  128'(err),      128'd0);
    check("rst_rdy",  128'(din_rdy),  128'd1);
    check("rst_dout", dout,           128'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_block(vecs[i].flag, vecs[i].mode, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-pressure: first result waits, second block stalls in FINAL.
    @(posedge clk); #1;
    dout_rdy = 1'b0;
    keyex    = keys128;
    use_inv  = 1'b0;
    flag = 1'b1; mode = 2'd0; din = PT; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    n = 1;
    while (!dout_vld && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_first", dout, C128);
    use_inv = 1'b1;
    flag = 1'b0; din = C128; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    flag = 1'b1; din = '0;
    hold_ok = 1'b1;
    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      if (dout !== C128 || dout_vld !== 1'b1 || din_rdy !== 1'b0) hold_ok = 1'b0;
    end
    check("bp_hold", 128'(hold_ok), 128'd1);
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp_second", dout, PT);
    check("bp_second_vld", 128'(dout_vld), 128'd1);
    @(posedge clk); #1;
    check("bp_drain_vld", 128'(dout_vld), 128'd0);
    check("bp_drain_rdy", 128'(din_rdy), 128'd1);

    // Reserved mode on the full build.
    flag = 1'b1; mode = 2'b11; din = PT; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    check("rej11_err", 128'(err), 128'd1);
    check("rej11_vld", 128'(dout_vld), 128'd0);
    check("rej11_rdy", 128'(din_rdy), 128'd1);
    @(posedge clk); #1;
    check("rej11_err_clr", 128'(err), 128'd0);
    check("rej11_vld2", 128'(dout_vld), 128'd0);

    // AES-256 on the NR_MAX=10 build, then AES-128 still works there.
    keyex = keys256;
    mode = 2'b10; b_din_vld = 1'b1;
    @(posedge clk); #1;
    b_din_vld = 1'b0;
    check("rej10_err", 128'(b_err), 128'd1);
    check("rej10_vld", 128'(b_dout_vld), 128'd0);
    check("rej10_rdy", 128'(b_din_rdy), 128'd1);
    @(posedge clk); #1;
    check("rej10_err_clr", 128'(b_err), 128'd0);
    check("rej10_vld2", 128'(b_dout_vld), 128'd0);
    keyex = keys128;
    flag = 1'b1; mode = 2'b00; din = PT; b_din_vld = 1'b1;
    @(posedge clk); #1;
    b_din_vld = 1'b0;
    n = 1;
    while (!b_dout_vld && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("nr10_lat", 128'(n), 128'd11);
    check("nr10_dout", b_dout, C128);
    @(posedge clk); #1;

    // Reset mid-block around round 5, then a fresh block.
    use_inv = 1'b0;
    flag = 1'b1; mode = 2'd0; din = PT; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_vld", 128'(dout_vld), 128'd0);
    check("mid_rst_rdy", 128'(din_rdy), 128'd1);
    check("mid_rst_dout", dout, 128'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dout_vld) n++;
    end
    check("mid_rst_no_out", 128'(n), 128'd0);
    run_block(1'b1, 2'd0, PT, C128, "post_rst");

    // Back-to-back alternating encrypt-128 / decrypt-256.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_block(1'b1, 2'd0, PT, C128, $sformatf("alt%0d", i));
      else            run_block(1'b0, 2'd2, C256, PT, $sformatf("alt%0d", i));
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
